// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  // One prefetched word together with the byte address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: ROM address/data, redirect request and the decode handshake.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // The fetch unit drives the ROM address and the decode-facing outputs.
  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // ROM, execute and decode side of the same bundle.
  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush takes priority over enqueue.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       rd_ptr_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW:0]         count_q;
  logic                do_enq;
  logic                do_deq;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign do_deq = deq & ~empty;
  assign do_enq = enq & (~full | do_deq);
  assign head   = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
    end
  end

  // Entry storage; a write into the slot being popped is safe because the pop reads before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_enq && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the combinational ROM, buffers
// {pc, instr} pairs and hands them to decode over valid/ready. Redirects flush the buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  fetch_if.master      bus,
  output logic [31:0]  fetch_count
);

  // Byte-address mask that keeps the PC inside the ROM window.
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * WORD_BYTES) - 32'd1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         fifo_full;
  logic         fifo_empty;
  logic         deq;
  logic         enq;
  fetch_entry_t head;
  fetch_entry_t new_entry;

  assign bus.imem_addr = fetch_pc_q;
  assign deq           = ~fifo_empty & bus.out_ready;
  // Redirect suppresses the push; a full buffer only takes a word when the head leaves.
  assign enq           = ~bus.redirect & (~fifo_full | deq);
  assign new_entry     = '{pc: fetch_pc_q, instr: bus.imem_instr};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .flush (bus.redirect),
    .wdata (new_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Next fetch PC and perf counter: redirect wins, otherwise advance only on a push.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_count_d = fetch_count_q;
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc) & PC_MASK;
    end else if (enq) begin
      fetch_pc_d    = (fetch_pc_q + 32'(WORD_BYTES)) & PC_MASK;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC & PC_MASK;
      fetch_count_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Decode-facing outputs read as zero whenever nothing is valid.
  always_comb begin
    bus.out_valid = ~fifo_empty;
    bus.out_pc    = '0;
    bus.out_instr = '0;
    if (!fifo_empty) begin
      bus.out_pc    = head.pc;
      bus.out_instr = head.instr;
    end
  end

  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; ROM word i reads as 32'hA000_0000 | i.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] fetch_count;
  int          total;
  int          bad;

  fetch_if bus ();

  instr_fetch_unit #(
    .DEPTH      (2),
    .RESET_PC   (32'h0),
    .IMEM_WORDS (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fetch_count (fetch_count)
  );

  assign bus.imem_instr = 32'hA000_0000 | {2'b00, bus.imem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, ".pc"}, bus.out_pc, pc);
    chk({tag, ".instr"}, bus.out_instr, ins);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;
    #1;
    // Reset state
    chk_out("rst", 1'b0, 32'h0, 32'h0);
    chk("rst.addr", bus.imem_addr, 32'h0);
    chk("rst.cnt", fetch_count, 32'h0);

    // 1: streaming with out_ready=1
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    chk("t1.pre", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk_out("t1.c1", 1'b1, 32'h0, 32'hA000_0000);
    step();
    chk_out("t1.c2", 1'b1, 32'h4, 32'hA000_0001);
    step();
    chk_out("t1.c3", 1'b1, 32'h8, 32'hA000_0002);
    step();
    chk_out("t1.c4", 1'b1, 32'hC, 32'hA000_0003);
    step();
    chk_out("t1.c5", 1'b1, 32'h10, 32'hA000_0004);
    chk("t1.cnt", fetch_count, 32'd5);

    // 2: stall from reset, buffer fills at two entries
    reset = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    chk("t2.rst.valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_out("t2.full", 1'b1, 32'h0, 32'hA000_0000);
    chk("t2.addr", bus.imem_addr, 32'h8);
    chk("t2.cnt", fetch_count, 32'd2);

    // 3: redirect to 0x23 with full buffer and out_ready=1
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h23;
    step();
    bus.redirect = 1'b0;
    chk_out("t3.flush", 1'b0, 32'h0, 32'h0);
    chk("t3.addr", bus.imem_addr, 32'h20);
    chk("t3.cnt", fetch_count, 32'd2);
    step();
    chk_out("t3.tgt", 1'b1, 32'h20, 32'hA000_0008);
    chk("t3.cnt2", fetch_count, 32'd3);

    // 4: redirect near the top of the ROM and wrap to 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hF8;
    step();
    bus.redirect = 1'b0;
    chk("t4.valid0", {31'd0, bus.out_valid}, 32'd0);
    chk("t4.addr0", bus.imem_addr, 32'hF8);
    step();
    chk_out("t4.i0", 1'b1, 32'hF8, 32'hA000_003E);
    step();
    chk_out("t4.i1", 1'b1, 32'hFC, 32'hA000_003F);
    chk("t4.addrwrap", bus.imem_addr, 32'h0);
    step();
    chk_out("t4.i2", 1'b1, 32'h0, 32'hA000_0000);
    chk("t4.addr", bus.imem_addr, 32'h4);
    chk("t4.cnt", fetch_count, 32'd6);

    // 5: async reset with a full buffer
    bus.out_ready = 1'b0;
    step();
    step();
    chk("t5.pre.addr", bus.imem_addr, 32'h8);
    reset = 1'b1;
    #1;
    chk_out("t5.async", 1'b0, 32'h0, 32'h0);
    chk("t5.addr", bus.imem_addr, 32'h0);
    chk("t5.cnt", fetch_count, 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("t5.rel.cnt", fetch_count, 32'h0);
    bus.out_ready = 1'b1;
    step();
    chk_out("t5.first", 1'b1, 32'h0, 32'hA000_0000);
    chk("t5.cnt1", fetch_count, 32'd1);

    // 6: redirect coincident with a handshake; no stale entry afterwards
    bus.out_ready = 1'b0;
    step();
    chk("t6.cnt.pre", fetch_count, 32'd2);
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    chk("t6.valid0", {31'd0, bus.out_valid}, 32'd0);
    chk("t6.addr", bus.imem_addr, 32'h40);
    step();
    chk_out("t6.tgt", 1'b1, 32'h40, 32'hA000_0010);
    step();
    chk_out("t6.next", 1'b1, 32'h44, 32'hA000_0011);
    chk("t6.cnt", fetch_count, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
